// File: rtl/btn_debounce_pkg.sv
// Shared debounce defaults: sample prescale for the 50 MHz board and for simulation, stability depth.
// Also provides the counter-width helper used by the prescaler and the per-bit filters.
package btn_debounce_pkg;

  localparam int PRESCALE_BOARD = 1000;  // 20 us sample period at 50 MHz
  localparam int PRESCALE_SIM   = 1;
  localparam int STABLE_DEFAULT = 4;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce_db_cell.sv
// One input bit: 2-flop sync, tick-gated stability filter, edge pulses, sticky press latch.
// Latency: 2 clk sync + STABLE ticks; no backpressure, pulses are fire-and-forget.
module db_cell
  import btn_debounce_pkg::*;
#(
  parameter int STABLE = STABLE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  input  logic clr,
  output logic level,
  output logic press,
  output logic rel,
  output logic sticky
);

  localparam int            CW       = cnt_width(STABLE);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
      rel    <= 1'b0;
      sticky <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      press <= 1'b0;
      rel   <= 1'b0;
      if (tick) begin
        if (s2 == level) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          level <= s2;
          cnt   <= '0;
          press <= s2;
          rel   <= ~s2;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
      // A press in flight outranks a simultaneous clear so no press is lost.
      if (press) begin
        sticky <= 1'b1;
      end else if (clr) begin
        sticky <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// Debounces WIDTH raw buttons for PORTI; shared prescaler drives one sample tick for all bits.
// Latency: 2 clk + wait to next tick + (STABLE-1) ticks; no backpressure.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int PRESCALE = PRESCALE_BOARD,
  parameter int STABLE   = STABLE_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn_raw,
  input  logic [WIDTH-1:0] clr,
  output logic [WIDTH-1:0] btn_o,
  output logic [WIDTH-1:0] press_p,
  output logic [WIDTH-1:0] release_p,
  output logic [WIDTH-1:0] sticky,
  output logic             tick_o
);

  localparam int             PCW     = cnt_width(PRESCALE);
  localparam logic [PCW-1:0] PC_LAST = PCW'(PRESCALE - 1);

  logic [PCW-1:0] pc;

  // tick_o is registered off the terminal count, so it trails pc by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc     <= '0;
      tick_o <= 1'b0;
    end else begin
      tick_o <= (pc == PC_LAST);
      pc     <= (pc == PC_LAST) ? '0 : pc + PCW'(1);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    db_cell #(
      .STABLE (STABLE)
    ) u_cell (
      .clk    (clk),
      .reset  (reset),
      .tick   (tick_o),
      .raw    (btn_raw[i]),
      .clr    (clr[i]),
      .level  (btn_o[i]),
      .press  (press_p[i]),
      .rel    (release_p[i]),
      .sticky (sticky[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench: a PRESCALE=4 instance for reset/glitch/tick cases and a PRESCALE=1 instance
// driven from a cycle-exact vector table; WIDTH=4, STABLE=3 for both.
module tb_btn_debounce;

  logic       clk = 1'b0;
  logic       rst, rst1;
  logic [3:0] raw, clr, btn, press, rel, stk;
  logic       tick;
  logic [3:0] raw1, clr1, btn1, press1, rel1, stk1;
  logic       tick1;

  int tests = 0;
  int errors = 0;

  always #5 clk = ~clk;

  btn_debounce #(.WIDTH(4), .PRESCALE(4), .STABLE(3)) dut (
    .clk(clk), .reset(rst), .btn_raw(raw), .clr(clr), .btn_o(btn),
    .press_p(press), .release_p(rel), .sticky(stk), .tick_o(tick)
  );

  btn_debounce #(.WIDTH(4), .PRESCALE(1), .STABLE(3)) dut1 (
    .clk(clk), .reset(rst1), .btn_raw(raw1), .clr(clr1), .btn_o(btn1),
    .press_p(press1), .release_p(rel1), .sticky(stk1), .tick_o(tick1)
  );

  typedef struct {
    int         n;
    logic [3:0] raw, clr, btn, press, rel, stk;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input int n, input logic [3:0] r, input logic [3:0] c,
                              input logic [3:0] b, input logic [3:0] p,
                              input logic [3:0] l, input logic [3:0] s);
    vec_t v;
    v.n = n; v.raw = r; v.clr = c; v.btn = b; v.press = p; v.rel = l; v.stk = s;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reset just released at a negedge with raw held at val: accept lands on the 13th edge.
  task automatic run_from_release(input string name, input logic [3:0] val);
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      chk({name, " btn_o"},     btn,   (k >= 13) ? val : 4'h0);
      chk({name, " press_p"},   press, (k == 13) ? val : 4'h0);
      chk({name, " release_p"}, rel,   4'h0);
      chk({name, " sticky"},    stk,   (k >= 14) ? val : 4'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rst1 = 1'b1;
    raw = 4'hF; clr = 4'h0; raw1 = 4'h0; clr1 = 4'h0;

    // (n, raw, clr, btn_o, press_p, release_p, sticky) for the PRESCALE=1 instance
    add(4, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 4'h2, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0);
    add(1, 4'h2, 4'h0, 4'h2, 4'h0, 4'h0, 4'h2);
    add(4, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h2);
    add(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h2);
    add(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2);
    add(4, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2);
    add(1, 4'h4, 4'h0, 4'h4, 4'h4, 4'h0, 4'h2);
    add(1, 4'h4, 4'h0, 4'h4, 4'h0, 4'h0, 4'h6);
    add(1, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0, 4'h2);
    add(1, 4'h4, 4'h0, 4'h4, 4'h0, 4'h0, 4'h2);
    add(4, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h2);
    add(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h2);
    add(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2);
    add(4, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0, 4'h2);
    add(1, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h2);
    add(1, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0, 4'h6);
    add(1, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0, 4'h2);
    add(1, 4'h4, 4'h0, 4'h4, 4'h0, 4'h0, 4'h2);
    add(2, 4'h5, 4'h0, 4'h4, 4'h0, 4'h0, 4'h2);
    add(4, 4'h4, 4'h0, 4'h4, 4'h0, 4'h0, 4'h2);
    add(3, 4'h5, 4'h0, 4'h4, 4'h0, 4'h0, 4'h2);
    add(1, 4'h4, 4'h0, 4'h4, 4'h0, 4'h0, 4'h2);
    add(1, 4'h4, 4'h0, 4'h5, 4'h1, 4'h0, 4'h2);
    add(2, 4'h4, 4'h0, 4'h5, 4'h0, 4'h0, 4'h3);
    add(1, 4'h4, 4'h0, 4'h4, 4'h0, 4'h1, 4'h3);
    add(1, 4'h4, 4'h0, 4'h4, 4'h0, 4'h0, 4'h3);

    repeat (3) @(negedge clk);
    chk("reset btn_o",     btn,   4'h0);
    chk("reset press_p",   press, 4'h0);
    chk("reset release_p", rel,   4'h0);
    chk("reset sticky",    stk,   4'h0);
    chk("reset tick_o",    tick,  1'b0);
    chk("reset1 tick_o",   tick1, 1'b0);

    rst1 = 1'b0;
    repeat (2) @(negedge clk);
    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].n; r++) begin
        @(negedge clk);
        raw1 = tbl[i].raw;
        clr1 = tbl[i].clr;
        @(posedge clk); #1;
        chk($sformatf("vec%0d.%0d btn_o", i, r),     btn1,   tbl[i].btn);
        chk($sformatf("vec%0d.%0d press_p", i, r),   press1, tbl[i].press);
        chk($sformatf("vec%0d.%0d release_p", i, r), rel1,   tbl[i].rel);
        chk($sformatf("vec%0d.%0d sticky", i, r),    stk1,   tbl[i].stk);
      end
    end
    chk("prescale1 tick_o", tick1, 1'b1);

    // All four bits held high through reset.
    @(negedge clk);
    rst = 1'b0;
    run_from_release("startup", 4'hF);

    // Tick period and width from a fresh reset.
    @(negedge clk);
    rst = 1'b1; raw = 4'h0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      chk($sformatf("tick_o edge %0d", k), tick, (k % 4 == 0) ? 1'b1 : 1'b0);
    end

    // 5-clk pulse on bit 0 spans at most two ticks.
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      raw = (k < 5) ? 4'h1 : 4'h0;
      @(posedge clk); #1;
      chk("glitch btn_o[0]",   btn[0],   1'b0);
      chk("glitch press_p[0]", press[0], 1'b0);
    end

    // Bit 3 filter reaches count 2, then reset must discard it.
    @(negedge clk);
    rst = 1'b1; raw = 4'h8;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      chk("prefilter btn_o",   btn,   4'h0);
      chk("prefilter press_p", press, 4'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset btn_o",   btn,   4'h0);
    chk("midreset press_p", press, 4'h0);
    chk("midreset sticky",  stk,   4'h0);
    rst = 1'b0;
    run_from_release("refilter", 4'h8);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
